// File: rtl/tft_pkg.sv
// Shared opcodes, sequencer state encoding and init-ROM word slicing for the
// TFT init sequencer.
package tft_pkg;

  localparam logic [1:0] OP_CMD = 2'b00;
  localparam logic [1:0] OP_DAT = 2'b01;
  localparam logic [1:0] OP_DLY = 2'b10;
  localparam logic [1:0] OP_END = 2'b11;

  localparam int unsigned MAX_DW = 16;

  // ROM words of narrower buses are zero-extended into this container.
  typedef logic [MAX_DW+1:0] rom_word_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RST_LOW,
    S_RST_WAIT,
    S_FETCH,
    S_EXEC,
    S_WRITE,
    S_DELAY,
    S_READY
  } seq_state_t;

  function automatic logic [1:0] rom_op(input rom_word_t w, input int unsigned dw);
    return (dw == 8) ? w[9:8] : w[17:16];
  endfunction

  // Delay payloads on an 8-bit bus only carry 8 bits of microseconds.
  function automatic logic [15:0] rom_payload(input rom_word_t w, input int unsigned dw);
    return (dw == 8) ? {8'h00, w[7:0]} : w[15:0];
  endfunction

endpackage

// File: rtl/tft_bus_writer.sv
// 8080-style single write engine: CS/WR strobe with programmable low and high
// phases, followed by one CS-high cycle carrying a done pulse.
module tft_bus_writer #(
  parameter int DATA_W      = 16,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rs,
  input  logic [DATA_W-1:0] data,
  output logic              done,
  output logic              lcd_cs,
  output logic              lcd_rs,
  output logic              lcd_wr,
  output logic [DATA_W-1:0] lcd_data
);

  localparam int MAX_PH = (WR_LOW_CYC > WR_HIGH_CYC) ? WR_LOW_CYC : WR_HIGH_CYC;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam logic [PH_W-1:0] LOW_LAST  = PH_W'(WR_LOW_CYC - 1);
  localparam logic [PH_W-1:0] HIGH_LAST = PH_W'(WR_HIGH_CYC - 1);
  localparam logic [PH_W-1:0] PH_ONE    = PH_W'(1);

  typedef enum logic [1:0] {E_IDLE, E_LOW, E_HIGH, E_DONE} eng_state_t;

  eng_state_t      eng_state;
  logic [PH_W-1:0] ph_cnt;

  // RS and DATA are captured at start and held until the next write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eng_state <= E_IDLE;
      ph_cnt    <= '0;
      done      <= 1'b0;
      lcd_cs    <= 1'b1;
      lcd_rs    <= 1'b0;
      lcd_wr    <= 1'b1;
      lcd_data  <= '0;
    end else begin
      case (eng_state)
        E_IDLE: begin
          done <= 1'b0;
          if (start) begin
            lcd_cs    <= 1'b0;
            lcd_wr    <= 1'b0;
            lcd_rs    <= rs;
            lcd_data  <= data;
            ph_cnt    <= LOW_LAST;
            eng_state <= E_LOW;
          end
        end
        E_LOW: begin
          if (ph_cnt == '0) begin
            lcd_wr    <= 1'b1;
            ph_cnt    <= HIGH_LAST;
            eng_state <= E_HIGH;
          end else begin
            ph_cnt <= ph_cnt - PH_ONE;
          end
        end
        E_HIGH: begin
          if (ph_cnt == '0) begin
            lcd_cs    <= 1'b1;
            done      <= 1'b1;
            eng_state <= E_DONE;
          end else begin
            ph_cnt <= ph_cnt - PH_ONE;
          end
        end
        E_DONE: begin
          done      <= 1'b0;
          eng_state <= E_IDLE;
        end
        default: eng_state <= E_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/tft_init_sequencer.sv
// TFT panel controller: hardware reset pulse, init-ROM walk, then a valid/ready
// host write port. Optional backlight PWM is enabled with TFT_BL_PWM_EN.
module tft_init_sequencer
  import tft_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ROM_AW      = 9,
  parameter int US_CYC      = 10,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1,
  parameter int RST_LOW_US  = 10,
  parameter int RST_WAIT_US = 120
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W+1:0] rom_data,
  input  logic              host_valid,
  input  logic              host_rs,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic              LCD_RST,
  output logic              LCD_CS,
  output logic              LCD_RS,
  output logic              LCD_WR,
  output logic              LCD_RD,
  output logic              BL_CTR,
  output logic [DATA_W-1:0] LCD_DATA,
  output logic              oDone
`ifdef TFT_BL_PWM_EN
  ,
  input  logic [7:0]        bl_duty
`endif
);

  localparam int unsigned DW_U = DATA_W;
  localparam int CNT_W = 16 + $clog2(US_CYC);
  localparam logic [CNT_W-1:0]  CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]  RST_LOW_CYC  = CNT_W'(RST_LOW_US * US_CYC);
  localparam logic [CNT_W-1:0]  RST_WAIT_CYC = CNT_W'(RST_WAIT_US * US_CYC);
  localparam logic [ROM_AW-1:0] ADDR_LAST    = '1;
  localparam logic [ROM_AW-1:0] ADDR_ONE     = ROM_AW'(1);

  seq_state_t       state;
  logic             en_q;
  logic [CNT_W-1:0] cnt;

  rom_word_t        rom_word;
  logic [1:0]       op;
  logic [CNT_W-1:0] dly_cyc;
  logic             host_fire;
  logic             exec_write;
  logic             advance;

  logic             eng_start;
  logic             eng_rs;
  logic [DATA_W-1:0] eng_data;
  logic             eng_done;

  assign rom_word  = rom_word_t'(rom_data);
  assign op        = rom_op(rom_word, DW_U);
  assign dly_cyc   = CNT_W'(rom_payload(rom_word, DW_U)) * CNT_W'(US_CYC);
  assign host_fire = host_valid && host_ready;

  assign exec_write = (state == S_EXEC) && ((op == OP_CMD) || (op == OP_DAT));

  // Every way an entry can finish: write done, delay expired, or a zero delay.
  assign advance = ((state == S_WRITE) && eng_done) ||
                   ((state == S_DELAY) && (cnt == '0)) ||
                   ((state == S_EXEC) && (op == OP_DLY) && (dly_cyc == '0));

  // The engine is shared: the host owns it only in READY.
  assign eng_start = exec_write || host_fire;
  assign eng_rs    = (state == S_READY) ? host_rs : (op == OP_DAT);
  assign eng_data  = (state == S_READY) ? host_data : rom_data[DATA_W-1:0];

  assign LCD_RD = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      en_q       <= 1'b0;
      cnt        <= '0;
      rom_addr   <= '0;
      LCD_RST    <= 1'b1;
      host_ready <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      en_q <= en;
      if (advance) begin
        if (rom_addr == ADDR_LAST) begin
          state      <= S_READY;
          oDone      <= 1'b1;
          host_ready <= 1'b1;
        end else begin
          rom_addr <= rom_addr + ADDR_ONE;
          state    <= S_FETCH;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (en && !en_q) begin
              LCD_RST <= 1'b0;
              cnt     <= RST_LOW_CYC - CNT_ONE;
              state   <= S_RST_LOW;
            end
          end
          S_RST_LOW: begin
            if (cnt == '0) begin
              LCD_RST <= 1'b1;
              cnt     <= RST_WAIT_CYC - CNT_ONE;
              state   <= S_RST_WAIT;
            end else begin
              cnt <= cnt - CNT_ONE;
            end
          end
          S_RST_WAIT: begin
            if (cnt == '0) state <= S_FETCH;
            else           cnt   <= cnt - CNT_ONE;
          end
          S_FETCH: state <= S_EXEC;
          S_EXEC: begin
            if (op == OP_END) begin
              state      <= S_READY;
              oDone      <= 1'b1;
              host_ready <= 1'b1;
            end else if (op == OP_DLY) begin
              cnt   <= dly_cyc - CNT_ONE;
              state <= S_DELAY;
            end else begin
              state <= S_WRITE;
            end
          end
          S_WRITE: state <= S_WRITE;
          S_DELAY: cnt <= cnt - CNT_ONE;
          S_READY: begin
            if (host_fire)     host_ready <= 1'b0;
            else if (eng_done) host_ready <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  tft_bus_writer #(
    .DATA_W      (DATA_W),
    .WR_LOW_CYC  (WR_LOW_CYC),
    .WR_HIGH_CYC (WR_HIGH_CYC)
  ) u_writer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (eng_start),
    .rs       (eng_rs),
    .data     (eng_data),
    .done     (eng_done),
    .lcd_cs   (LCD_CS),
    .lcd_rs   (LCD_RS),
    .lcd_wr   (LCD_WR),
    .lcd_data (LCD_DATA)
  );

`ifdef TFT_BL_PWM_EN
  logic [7:0] pwm_cnt;
  logic       bl_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      bl_q    <= 1'b0;
    end else begin
      pwm_cnt <= pwm_cnt + 8'd1;
      bl_q    <= (state == S_READY) && (pwm_cnt < bl_duty);
    end
  end

  assign BL_CTR = bl_q;
`else
  // Backlight follows the registered done flag: off until READY, then on.
  assign BL_CTR = oDone;
`endif

endmodule
